jr_queue_rs: RTL and testbench

Parametrised, multi-entry reservation station for jump-register (indirect) branches in the out-of-order core. It holds up to DEPTH pending jumps in program order and snoops NUM_CDB result broadcast channels (ALU and load) for each jump's source tag. It releases resolved targets strictly in order to fetch over a valid/ready handshake, and supports pipeline flush.

---
 rtl/ooo_pkg.sv | 19 +
 rtl/rs_cdb_match.sv | 36 +++
 rtl/jr_queue_rs.sv | 154 +++++++++++++++
 tb/tb_jr_queue_rs.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: default widths, the null rename tag and
// the per-entry state encoding used by the reservation stations.
package ooo_pkg;

  localparam int unsigned TAG_W_DEF  = 5;
  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;

  // Tag 0 means the source value is already available.
  localparam int unsigned NULL_TAG = 0;

  // Encoded as {valid, rdy}.
  typedef enum logic [1:0] {
    EntFree = 2'b00,
    EntWait = 2'b10,
    EntRdy  = 2'b11
  } ent_state_e;

endpackage

// File: rtl/rs_cdb_match.sv
// Compares one source tag against every result broadcast channel and returns the
// low ADDR_W bits of the matching channel's data, highest channel index winning.
module rs_cdb_match
  import ooo_pkg::*;
#(
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned NUM_CDB = 4
) (
  input  logic [TAG_W-1:0]          tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      hit,
  output logic [ADDR_W-1:0]         data
);

  // Only the target bits of each broadcast are consumed.
  logic unused_data;
  assign unused_data = ^cdb_data;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Ascending scan: a later (higher) channel overrides an earlier hit.
    for (int i = 0; i < int'(NUM_CDB); i++) begin
      if (cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] != TAG_W'(NULL_TAG)) &&
          (cdb_tag[i*TAG_W +: TAG_W] == tag)) begin
        hit  = 1'b1;
        data = cdb_data[i*DATA_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/jr_queue_rs.sv
// In-order reservation station for indirect jumps: circular buffer of pending
// targets that snoop the result broadcasts and drain to fetch over valid/ready.
module jr_queue_rs
  import ooo_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned NUM_CDB = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [TAG_W-1:0]             alloc_tag,
  input  logic [ADDR_W-1:0]            alloc_val,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]    cdb_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  ent_state_e        st_q   [DEPTH];
  ent_state_e        st_d   [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  snoop_hit;
  logic [ADDR_W-1:0] snoop_data [DEPTH];
  logic              alloc_hit;
  logic [ADDR_W-1:0] alloc_data;
  logic              do_alloc, do_pop;

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_match
    rs_cdb_match #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_CDB(NUM_CDB)
    ) u_match (
      .tag      (tag_q[g]),
      .cdb_valid(cdb_valid),
      .cdb_tag  (cdb_tag),
      .cdb_data (cdb_data),
      .hit      (snoop_hit[g]),
      .data     (snoop_data[g])
    );
  end

  // Same-cycle bypass for the entry being allocated.
  rs_cdb_match #(
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_CDB(NUM_CDB)
  ) u_alloc_match (
    .tag      (alloc_tag),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .hit      (alloc_hit),
    .data     (alloc_data)
  );

  // Outputs come from registered state only.
  assign alloc_ready = (count_q != CNT_W'(DEPTH));
  assign out_valid   = (st_q[head_q] == EntRdy);
  assign out_addr    = addr_q[head_q];
  assign count       = count_q;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_pop      = out_valid && out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      st_d[i]   = st_q[i];
      tag_d[i]  = tag_q[i];
      addr_d[i] = addr_q[i];
    end

    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) st_d[i] = EntFree;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if ((st_q[i] == EntWait) && snoop_hit[i]) begin
          st_d[i]   = EntRdy;
          addr_d[i] = snoop_data[i];
          tag_d[i]  = '0;
        end
      end
      if (do_pop) begin
        st_d[head_q] = EntFree;
        head_d       = head_q + PTR_W'(1);
      end
      // Tail never equals a poppable head when not full, so no write conflict.
      if (do_alloc) begin
        tag_d[tail_q] = '0;
        if (alloc_tag == TAG_W'(NULL_TAG)) begin
          st_d[tail_q]   = EntRdy;
          addr_d[tail_q] = alloc_val;
        end else if (alloc_hit) begin
          st_d[tail_q]   = EntRdy;
          addr_d[tail_q] = alloc_data;
        end else begin
          st_d[tail_q]   = EntWait;
          tag_d[tail_q]  = alloc_tag;
          addr_d[tail_q] = '0;
        end
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        st_q[i]   <= EntFree;
        tag_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        st_q[i]   <= st_d[i];
        tag_q[i]  <= tag_d[i];
        addr_q[i] <= addr_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_jr_queue_rs.sv
// Bench for jr_queue_rs: directed vector table for the corner cases, an async
// reset probe, then random traffic against a queue-based reference model.
module tb_jr_queue_rs;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 10;
  localparam int NUM_CDB = 4;
  localparam int CNT_W   = 3;

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [TAG_W-1:0]          alloc_tag;
  logic [ADDR_W-1:0]         alloc_val;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [ADDR_W-1:0]         out_addr;
  logic [CNT_W-1:0]          count;

  jr_queue_rs #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_CDB(NUM_CDB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc_valid(alloc_valid),
    .alloc_ready(alloc_ready),
    .alloc_tag  (alloc_tag),
    .alloc_val  (alloc_val),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              fl;
    logic              av;
    logic [4:0]        at;
    logic [9:0]        aval;
    logic [3:0]        cv;
    logic [3:0][4:0]   ct;
    logic [3:0][9:0]   cd;
    logic              ordy;
    logic              ov;
    logic [9:0]        oa;
    logic [2:0]        cnt;
    logic              ar;
  } vec_t;

  typedef struct {
    bit         rdy;
    logic [4:0] tag;
    logic [9:0] addr;
  } ment_t;

  vec_t  tbl[$];
  ment_t mq[$];
  ment_t me;
  int    checks;
  int    failures;
  bit    m_ov, m_pop, m_acc, m_hit;
  logic [9:0] m_data;

  function automatic vec_t mk(logic fl, logic av, logic [4:0] at, logic [9:0] aval,
                              logic [3:0] cv, logic [19:0] ct, logic [39:0] cd,
                              logic ordy, logic ov, logic [9:0] oa, logic [2:0] cnt,
                              logic ar);
    vec_t v;
    v.fl = fl; v.av = av; v.at = at; v.aval = aval; v.cv = cv; v.ct = ct; v.cd = cd;
    v.ordy = ordy; v.ov = ov; v.oa = oa; v.cnt = cnt; v.ar = ar;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    flush       = v.fl;
    alloc_valid = v.av;
    alloc_tag   = v.at;
    alloc_val   = v.aval;
    cdb_valid   = v.cv;
    cdb_tag     = v.ct;
    for (int c = 0; c < NUM_CDB; c++) cdb_data[c*DATA_W +: DATA_W] = {22'd0, v.cd[c]};
    out_ready   = v.ordy;
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_valid = 0; alloc_tag = '0; alloc_val = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; out_ready = 0;
  endtask

  // Highest-numbered valid channel carrying the (non-null) tag supplies the target.
  function automatic void lookup(input logic [4:0] t, output bit hit, output logic [9:0] d);
    hit = 0;
    d   = '0;
    if (t != 0) begin
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
          hit = 1;
          d   = cdb_data[c*DATA_W +: ADDR_W];
          break;
        end
      end
    end
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst = 1'b0;

    // {fl, av, tag, val, cv, ct{3..0}, cd{3..0}, ordy} -> {ov, oa, count, alloc_ready}
    tbl.push_back(mk(0, 1, 0, 10'h155, 4'b0000, '0, '0, 0,  1, 10'h155, 1, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0000, '0, '0, 1,  0, 10'h000, 0, 1));
    tbl.push_back(mk(0, 1, 7, 10'h000, 4'b0000, '0, '0, 0,  0, 10'h000, 1, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0100, {5'd0, 5'd7, 5'd0, 5'd0},
                     {10'h0, 10'h3A4, 10'h0, 10'h0}, 0,  1, 10'h3A4, 1, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0000, '0, '0, 1,  0, 10'h000, 0, 1));
    tbl.push_back(mk(0, 1, 5, 10'h000, 4'b0000, '0, '0, 0,  0, 10'h000, 1, 1));
    tbl.push_back(mk(0, 1, 6, 10'h000, 4'b0000, '0, '0, 0,  0, 10'h000, 2, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd6},
                     {10'h0, 10'h0, 10'h0, 10'h066}, 0,  0, 10'h000, 2, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0010, {5'd0, 5'd0, 5'd5, 5'd0},
                     {10'h0, 10'h0, 10'h055, 10'h0}, 0,  1, 10'h055, 2, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0000, '0, '0, 1,  1, 10'h066, 1, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0000, '0, '0, 1,  0, 10'h000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 10'h000, 4'b0000, '0, '0, 0,  0, 10'h000, 1, 1));
    tbl.push_back(mk(0, 1, 2, 10'h000, 4'b0000, '0, '0, 0,  0, 10'h000, 2, 1));
    tbl.push_back(mk(0, 1, 3, 10'h000, 4'b0000, '0, '0, 0,  0, 10'h000, 3, 1));
    tbl.push_back(mk(0, 1, 4, 10'h000, 4'b0000, '0, '0, 0,  0, 10'h000, 4, 0));
    tbl.push_back(mk(0, 1, 0, 10'h1FF, 4'b0000, '0, '0, 0,  0, 10'h000, 4, 0));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b1000, {5'd1, 5'd0, 5'd0, 5'd0},
                     {10'h101, 10'h0, 10'h0, 10'h0}, 0,  1, 10'h101, 4, 0));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd2},
                     {10'h0, 10'h0, 10'h0, 10'h102}, 1,  1, 10'h102, 3, 1));
    tbl.push_back(mk(0, 1, 0, 10'h0AB, 4'b0000, '0, '0, 1,  0, 10'h000, 3, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0011, {5'd0, 5'd0, 5'd4, 5'd3},
                     {10'h0, 10'h0, 10'h104, 10'h103}, 0,  1, 10'h103, 3, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0000, '0, '0, 1,  1, 10'h104, 2, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0000, '0, '0, 1,  1, 10'h0AB, 1, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0000, '0, '0, 1,  0, 10'h000, 0, 1));
    tbl.push_back(mk(0, 1, 9, 10'h000, 4'b0000, '0, '0, 0,  0, 10'h000, 1, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b1001, {5'd9, 5'd0, 5'd0, 5'd9},
                     {10'h022, 10'h0, 10'h0, 10'h011}, 0,  1, 10'h022, 1, 1));
    tbl.push_back(mk(0, 1, 9, 10'h000, 4'b1001, {5'd9, 5'd0, 5'd0, 5'd9},
                     {10'h044, 10'h0, 10'h0, 10'h033}, 1,  1, 10'h044, 1, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0000, '0, '0, 1,  0, 10'h000, 0, 1));
    tbl.push_back(mk(0, 1, 0, 10'h001, 4'b0000, '0, '0, 0,  1, 10'h001, 1, 1));
    tbl.push_back(mk(0, 1, 1, 10'h000, 4'b0000, '0, '0, 0,  1, 10'h001, 2, 1));
    tbl.push_back(mk(0, 1, 2, 10'h000, 4'b0000, '0, '0, 0,  1, 10'h001, 3, 1));
    tbl.push_back(mk(1, 1, 0, 10'h0AA, 4'b0000, '0, '0, 1,  0, 10'h000, 0, 1));
    tbl.push_back(mk(0, 1, 0, 10'h0BC, 4'b0000, '0, '0, 0,  1, 10'h0BC, 1, 1));
    tbl.push_back(mk(0, 0, 0, 10'h000, 4'b0000, '0, '0, 1,  0, 10'h000, 0, 1));

    #3;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_addr", 32'(out_addr), 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_alloc_ready", 32'(alloc_ready), 1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_alloc_ready", i), 32'(alloc_ready), 32'(tbl[i].ar));
      if (tbl[i].ov) chk($sformatf("vec%0d_out_addr", i), 32'(out_addr), 32'(tbl[i].oa));
    end

    // Async reset with a handshake and an allocation pending.
    idle_inputs();
    alloc_valid = 1; alloc_val = 10'h3C3;
    @(posedge clk);
    @(negedge clk);
    alloc_val = 10'h111; out_ready = 1;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_out_addr", 32'(out_addr), 0);
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_alloc_ready", 32'(alloc_ready), 1);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    mq.delete();
    for (int n = 0; n < 3000; n++) begin
      m_ov = (mq.size() > 0) && mq[0].rdy;
      chk("rnd_out_valid", 32'(out_valid), 32'(m_ov));
      chk("rnd_count", 32'(count), 32'(mq.size()));
      chk("rnd_alloc_ready", 32'(alloc_ready), 32'(mq.size() < DEPTH));
      if (m_ov) chk("rnd_out_addr", 32'(out_addr), 32'(mq[0].addr));

      flush       = ($urandom_range(0, 39) == 0);
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_tag   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      alloc_val   = 10'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_CDB; c++) begin
        cdb_valid[c]                  = 1'($urandom_range(0, 1));
        cdb_tag[c*TAG_W +: TAG_W]     = 5'($urandom_range(0, 7));
        cdb_data[c*DATA_W +: DATA_W]  = $urandom;
      end

      if (flush) begin
        mq.delete();
      end else begin
        m_pop = m_ov && out_ready;
        m_acc = alloc_valid && (mq.size() < DEPTH);
        for (int k = 0; k < mq.size(); k++) begin
          me = mq[k];
          if (!me.rdy) begin
            lookup(me.tag, m_hit, m_data);
            if (m_hit) begin
              me.rdy = 1; me.addr = m_data; me.tag = '0;
              mq[k] = me;
            end
          end
        end
        if (m_pop) void'(mq.pop_front());
        if (m_acc) begin
          if (alloc_tag == 0) begin
            me.rdy = 1; me.tag = '0; me.addr = alloc_val;
          end else begin
            lookup(alloc_tag, m_hit, m_data);
            me.rdy  = m_hit;
            me.tag  = m_hit ? 5'd0 : alloc_tag;
            me.addr = m_hit ? m_data : 10'd0;
          end
          mq.push_back(me);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
